iob_bus_merge: RTL and testbench

IOB_BUS_MERGE -- requirements
Module: iob_bus_merge

---
 rtl/iob_bus_merge_pkg.sv | 47 ++++
 rtl/iob_bus_merge_arb.sv | 37 +++
 rtl/iob_bus_merge.sv | 88 ++++++++
 tb/tb_iob_bus_merge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_bus_merge_pkg.sv
// Shared interconnect definitions for iob_bus_merge: state encoding, request/response
// layout {valid, addr, wdata, wstrb} / {rdata, ready}, and width/offset helpers.
package iob_bus_merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  // Request field offsets, LSB first: wstrb, wdata, addr, valid.
  localparam int REQ_WSTRB_LSB = 0;

  function automatic int req_wdata_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int req_valid_bit(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  localparam int RESP_READY_BIT = 0;
  localparam int RESP_RDATA_LSB = 1;

  localparam int REQ_W  = 1 + DEF_ADDR_W + DEF_DATA_W + DEF_DATA_W / 8;
  localparam int RESP_W = DEF_DATA_W + 1;

endpackage

// File: rtl/iob_bus_merge_arb.sv
// iob_arb2: two-request arbiter with one-hot grant. Fixed priority (request 0 wins)
// by default; round-robin on BUS_MERGE_RR_EN, where the pointer moves on each grant.
module iob_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

`ifdef BUS_MERGE_RR_EN
  // last_q = 1 means requester 1 was served most recently
  logic last_q;
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    last_d = last_q;
    if (upd && (|req)) last_d = gnt[1];
  end
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, upd};

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = 2'b01;
  end
`endif

endmodule

// File: rtl/iob_bus_merge.sv
// iob_bus_merge: merges two iob masters onto one slave; one transaction in flight.
// Define BUS_MERGE_RR_EN for round-robin arbitration instead of fixed m0 priority.
module iob_bus_merge
  import iob_bus_merge_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int RQ_W   = req_w(ADDR_W, DATA_W),
  localparam int RS_W   = resp_w(DATA_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RQ_W-1:0] m0_req,
  output logic [RS_W-1:0] m0_resp,
  input  logic [RQ_W-1:0] m1_req,
  output logic [RS_W-1:0] m1_resp,
  output logic [RQ_W-1:0] s_req,
  input  logic [RS_W-1:0] s_resp
);

  localparam int VALID_BIT = req_valid_bit(ADDR_W, DATA_W);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] txn_cnt_q;
  logic [31:0] txn_cnt_d;
  logic [1:0]  arb_req;
  logic [1:0]  gnt;
  logic        arb_upd;
  logic        s_ready;

  assign arb_req = {m1_req[VALID_BIT], m0_req[VALID_BIT]};
  assign s_ready = s_resp[RESP_READY_BIT];
  assign arb_upd = (state_q == ST_IDLE);

  iob_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .upd (arb_upd),
    .gnt (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      txn_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  // Grant is held until the slave answers, regardless of the master's valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0])      state_d = ST_GNT0;
        else if (gnt[1]) state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (s_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_req   = '0;
    m0_resp = '0;
    m1_resp = '0;
    case (state_q)
      ST_GNT0: begin
        s_req   = m0_req;
        m0_resp = s_resp;
      end
      ST_GNT1: begin
        s_req   = m1_req;
        m1_resp = s_resp;
      end
      default: ;
    endcase
  end

  assign txn_cnt_d = txn_cnt_q + {31'd0, (state_q != ST_IDLE) && s_ready};

endmodule

// File: tb/tb_iob_bus_merge.sv
// Self-checking bench for iob_bus_merge; arbitration order and counter come from a
// transaction-level model (pending masters, last-served pointer, running count).
module tb_iob_bus_merge;
  import iob_bus_merge_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RQW = req_w(AW, DW);
  localparam int RSW = resp_w(DW);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [RQW-1:0] m0_req = '0;
  logic [RQW-1:0] m1_req = '0;
  logic [RQW-1:0] s_req;
  logic [RSW-1:0] m0_resp;
  logic [RSW-1:0] m1_resp;
  logic [RSW-1:0] s_resp = '0;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt_model;
  int          last_served;

  always #5 clk = ~clk;

  iob_bus_merge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0_req  (m0_req),
    .m0_resp (m0_resp),
    .m1_req  (m1_req),
    .m1_resp (m1_resp),
    .s_req   (s_req),
    .s_resp  (s_resp)
  );

  function automatic logic [RQW-1:0] mk_req(input logic v, input logic [AW-1:0] a,
                                            input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RQW-1:0] rand_req();
    return mk_req(1'b1, AW'($urandom), DW'($urandom), (DW/8)'($urandom));
  endfunction

  function automatic int pick_winner(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef BUS_MERGE_RR_EN
      return (last_served == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // Entered one step after an edge with the state in IDLE and requests driven.
  task automatic serve_one(input int who, input int lat, input logic [DW-1:0] rdata,
                           input bit drop_early);
    logic [RQW-1:0] exp_req;
    logic [RSW-1:0] sr;
    logic [RSW-1:0] win_resp;
    logic [RSW-1:0] oth_resp;
    s_resp = {DW'($urandom), 1'b0};
    #2;
    total++;
    if (s_req !== '0 || m0_resp !== '0 || m1_resp !== '0) begin
      bad++;
      $display("FAIL idle_outputs: s_req=%h m0_resp=%h m1_resp=%h, required all zero",
               s_req, m0_resp, m1_resp);
    end
    exp_req = (who == 0) ? m0_req : m1_req;
    last_served = who;
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      if (drop_early && k == 0) begin
        if (who == 0) m0_req = '0;
        else          m1_req = '0;
        exp_req = '0;
      end
      sr = (k == lat) ? {rdata, 1'b1} : {DW'($urandom), 1'b0};
      s_resp = sr;
      #2;
      win_resp = (who == 0) ? m0_resp : m1_resp;
      oth_resp = (who == 0) ? m1_resp : m0_resp;
      total++;
      if (s_req !== exp_req) begin
        bad++;
        $display("FAIL grant_s_req m%0d cyc%0d: got %h, required %h", who, k, s_req, exp_req);
      end
      total++;
      if (win_resp !== sr) begin
        bad++;
        $display("FAIL winner_resp m%0d cyc%0d: got %h, required %h", who, k, win_resp, sr);
      end
      total++;
      if (oth_resp !== '0) begin
        bad++;
        $display("FAIL other_resp m%0d cyc%0d: got %h, required 0", who, k, oth_resp);
      end
    end
    @(posedge clk); #1;
    cnt_model = cnt_model + 32'd1;
    if (who == 0) m0_req = '0;
    else          m1_req = '0;
    s_resp = '0;
    total++;
    if (dut.txn_cnt_q !== cnt_model) begin
      bad++;
      $display("FAIL txn_count: got %h, required %h", dut.txn_cnt_q, cnt_model);
    end
    total++;
    if (dut.state_q !== ST_IDLE) begin
      bad++;
      $display("FAIL back_to_idle: state %0d, required IDLE", dut.state_q);
    end
  endtask

  task automatic run_round(input bit v0_in, input bit v1_in, input int lat);
    bit v0 = v0_in;
    bit v1 = v1_in;
    int w;
    if (v0) m0_req = rand_req();
    if (v1) m1_req = rand_req();
    while (v0 || v1) begin
      w = pick_winner(v0, v1);
      serve_one(w, lat, DW'($urandom), 1'b0);
      if (w == 0) v0 = 1'b0;
      else        v1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    m0_req = rand_req();
    m1_req = rand_req();
    s_resp = {DW'($urandom), 1'b1};
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (s_req !== '0 || m0_resp !== '0 || m1_resp !== '0) begin
      bad++;
      $display("FAIL reset_outputs: s_req=%h m0_resp=%h m1_resp=%h, required zero",
               s_req, m0_resp, m1_resp);
    end
    total++;
    if (dut.txn_cnt_q !== 32'd0 || dut.state_q !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: cnt=%h state=%0d, required 0/IDLE", dut.txn_cnt_q, dut.state_q);
    end
    m0_req = '0;
    m1_req = '0;
    s_resp = '0;
    rst    = 1'b0;
    cnt_model   = 32'd0;
    last_served = 1;
    @(posedge clk); #1;
    total++;
    if (s_req !== '0 || m0_resp !== '0 || m1_resp !== '0) begin
      bad++;
      $display("FAIL post_reset_outputs: s_req=%h m0_resp=%h m1_resp=%h, required zero",
               s_req, m0_resp, m1_resp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_m1_write();
    total++;
    if (dut.txn_cnt_q !== 32'd0) begin
      bad++;
      $display("FAIL count_before_write: got %h, required 0", dut.txn_cnt_q);
    end
    m1_req = mk_req(1'b1, AW'($urandom), 32'h1234_5678, 4'hF);
    serve_one(1, 1, DW'($urandom), 1'b0);
  endtask

  task automatic test_single_m0();
    m0_req = mk_req(1'b1, 32'h0000_0100, DW'($urandom), (DW/8)'($urandom));
    serve_one(0, 2, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_both_valid();
    run_round(1'b1, 1'b1, 1);
    run_round(1'b1, 1'b1, 0);
  endtask

  task automatic test_idle_ready();
    s_resp = {DW'($urandom), 1'b1};
    #2;
    total++;
    if (s_req !== '0 || m0_resp !== '0 || m1_resp !== '0) begin
      bad++;
      $display("FAIL idle_ready_leak: s_req=%h m0_resp=%h m1_resp=%h, required zero",
               s_req, m0_resp, m1_resp);
    end
    @(posedge clk); #1;
    s_resp = '0;
    total++;
    if (dut.state_q !== ST_IDLE || dut.txn_cnt_q !== cnt_model) begin
      bad++;
      $display("FAIL idle_ready_state: state=%0d cnt=%h, required IDLE/%h",
               dut.state_q, dut.txn_cnt_q, cnt_model);
    end
  endtask

  task automatic test_hold_grant();
    m0_req = rand_req();
    serve_one(0, 2, DW'($urandom), 1'b1);
  endtask

  task automatic test_random();
    bit v0;
    bit v1;
    for (int r = 0; r < 30; r++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v1 = 1'b1;
      run_round(v0, v1, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_reset_mid();
    m0_req = rand_req();
    @(posedge clk); #1;
    total++;
    if (dut.state_q !== ST_GNT0) begin
      bad++;
      $display("FAIL reset_mid_setup: state=%0d, required GNT0", dut.state_q);
    end
    s_resp = {DW'($urandom), 1'b1};
    rst    = 1'b1;
    #1;
    total++;
    if (s_req !== '0 || m0_resp !== '0 || m1_resp !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: s_req=%h m0_resp=%h m1_resp=%h, required zero",
               s_req, m0_resp, m1_resp);
    end
    total++;
    if (dut.state_q !== ST_IDLE || dut.txn_cnt_q !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_state: state=%0d cnt=%h, required IDLE/0", dut.state_q, dut.txn_cnt_q);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    m0_req = '0;
    s_resp = '0;
    cnt_model   = 32'd0;
    last_served = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    force dut.txn_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.txn_cnt_q;
    cnt_model = 32'hFFFF_FFFF;
    m1_req = rand_req();
    serve_one(1, 1, DW'($urandom), 1'b0);
    total++;
    if (dut.txn_cnt_q !== 32'd0) begin
      bad++;
      $display("FAIL count_wrap: got %h, required 0", dut.txn_cnt_q);
    end
  endtask

  initial begin
    test_reset();
    test_m1_write();
    test_single_m0();
    test_both_valid();
    test_idle_ready();
    test_hold_grant();
    test_random();
    test_reset_mid();
    test_both_valid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
